// File: rtl/serial_tx.sv
// Serial frame transmitter: shifts a variable-length payload out LSB first on w,
// optionally followed by an even-parity bit, then a one-cycle done marker.
module serial_tx #(
  parameter int WIDTH  = 8,
  parameter int PARITY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [4:0]       in_len,
  output logic             in_ready,
  output logic             w,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] SEND = 2'b01;
  localparam logic [1:0] PAR  = 2'b10;
  localparam logic [1:0] DONE = 2'b11;

  localparam logic [4:0] LEN_MAX = 5'(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             armed_q;
  logic             accept;
  logic [4:0]       len_clamp;

  assign len_clamp = (in_len > LEN_MAX) ? LEN_MAX : in_len;
  assign accept    = in_ready & in_valid;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = in_data;
          cnt_d   = len_clamp;
          par_d   = 1'b0;
          state_d = (len_clamp == 5'd0) ? DONE : SEND;
        end
      end
      SEND: begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q - 5'd1;
        par_d   = par_q ^ shift_q[0];
        if (cnt_q == 5'd1) begin
          state_d = (PARITY != 0) ? PAR : DONE;
        end
      end
      PAR:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // armed_q holds off acceptance on the edge that coincides with reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      armed_q <= 1'b1;
    end
  end

  assign in_ready = (state_q == IDLE) & armed_q;
  assign busy     = (state_q == SEND) | (state_q == PAR);
  assign done     = (state_q == DONE);
  assign state    = state_q;
  assign w        = (state_q == SEND) ? shift_q[0] :
                    (state_q == PAR)  ? par_q      : 1'b0;

endmodule
